// File: rtl/seven_segment_pkg.sv
// Shared constants and hex-to-segment glyph table for the seven-segment scan driver.
// Segment bit order is P,G,F,E,D,C,B,A (bit 7 down to bit 0), active-high.
package seven_segment_pkg;

   localparam logic [7:0] SEG_OFF = 8'h00;
   localparam int         DP_BIT  = 7;

   function automatic logic [7:0] hex_glyph(input logic [3:0] nibble);
      logic [7:0] g;
      g = SEG_OFF;
      case (nibble)
         4'h0: g = 8'h3F;
         4'h1: g = 8'h06;
         4'h2: g = 8'h5B;
         4'h3: g = 8'h4F;
         4'h4: g = 8'h66;
         4'h5: g = 8'h6D;
         4'h6: g = 8'h7D;
         4'h7: g = 8'h07;
         4'h8: g = 8'h7F;
         4'h9: g = 8'h6F;
         4'hA: g = 8'h77;
         4'hB: g = 8'h7C;
         4'hC: g = 8'h39;
         4'hD: g = 8'h5E;
         4'hE: g = 8'h79;
         default: g = 8'h71;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/clk_tick_div.sv
// Free-running divider: tick is high for one clock every RATIO clocks (combinational from the count).
// No backpressure; counts continuously from reset.
module clk_tick_div #(
   parameter int RATIO = 100
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int              CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

   logic [CNT_W-1:0] div_cnt;

   assign tick = (div_cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed hex display driver with double-buffered contents, PWM dimming and frame pulse;
// outputs registered one clock after scan state, no backpressure. Option: SEVEN_SEGMENT_LZ_BLANK_EN.
module seven_segment_scan
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int CLKDIV_RATIO   = 100,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b1,
   parameter int BRIGHT_W       = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] inp,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   sel,
   output logic [7:0]              data,
   output logic                    frame_done
);

   localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic                        tick;
   logic                        frame_end;
   logic [IDX_W-1:0]            idx;
   logic [NUM_DIGITS-1:0][3:0]  inp_nib;
   logic [NUM_DIGITS-1:0][3:0]  stage_val;
   logic [NUM_DIGITS-1:0][3:0]  disp_val;
   logic [NUM_DIGITS-1:0]       stage_dp;
   logic [NUM_DIGITS-1:0]       disp_dp;
   logic [BRIGHT_W-1:0]         pwm_cnt;
   logic                        on;
   logic [NUM_DIGITS-1:0]       blank;
   logic [7:0]                  glyph;
   logic [NUM_DIGITS-1:0]       sel_q;
   logic [7:0]                  data_q;

   assign inp_nib = inp;

   clk_tick_div #(
      .RATIO (CLKDIV_RATIO)
   ) u_div (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign frame_end = tick && (idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (tick) begin
         idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
   end

   // A load coinciding with the frame boundary bypasses staging so it is not delayed a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_val <= '0;
         stage_dp  <= '0;
         disp_val  <= '0;
         disp_dp   <= '0;
      end else begin
         if (load) begin
            stage_val <= inp_nib;
            stage_dp  <= dp_in;
         end
         if (frame_end) begin
            disp_val <= load ? inp_nib : stage_val;
            disp_dp  <= load ? dp_in   : stage_dp;
         end
      end
   end

`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
   // Walk down from the top digit; a digit blanks only while everything above it is zero too.
   always_comb begin
      logic zeros_above;
      zeros_above = 1'b1;
      blank       = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zeros_above = zeros_above && (disp_val[i] == 4'h0);
         blank[i]    = blank_lz && zeros_above;
      end
   end
`else
   logic unused_blank_lz;
   assign unused_blank_lz = blank_lz;
   assign blank           = '0;
`endif

   always_comb begin
      glyph         = blank[idx] ? SEG_OFF : hex_glyph(disp_val[idx]);
      glyph[DP_BIT] = disp_dp[idx];
   end

   assign on = (brightness == {BRIGHT_W{1'b1}}) || (pwm_cnt < brightness);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q      <= '0;
         data_q     <= SEG_OFF;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (on) begin
            sel_q  <= NUM_DIGITS'(1) << idx;
            data_q <= glyph;
         end else begin
            sel_q  <= '0;
            data_q <= SEG_OFF;
         end
      end
   end

   // Polarity lives after the register so reset always lands on the inactive pin level.
   assign sel  = SEL_ACTIVE_LOW ? ~sel_q  : sel_q;
   assign data = SEG_ACTIVE_LOW ? ~data_q : data_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: edge-count model plus directed literal checks.
`timescale 1ns/1ps
module tb_seven_segment_scan;

   localparam int N  = 4;
   localparam int R  = 4;
   localparam int BW = 4;
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
   localparam bit LZ_EN = 1'b1;
`else
   localparam bit LZ_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   inp = '0;
   logic [3:0]    dp_in = '0;
   logic          load = 1'b0;
   logic          blank_lz = 1'b0;
   logic [BW-1:0] brightness = 4'hF;
   logic [3:0]    sel, sel_hi;
   logic [7:0]    data, data_hi;
   logic          frame_done, frame_done_hi;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seven_segment_scan #(
      .NUM_DIGITS(N), .CLKDIV_RATIO(R), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1), .BRIGHT_W(BW)
   ) u_dut (
      .clk(clk), .rst(rst), .inp(inp), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
      .brightness(brightness), .sel(sel), .data(data), .frame_done(frame_done)
   );

   seven_segment_scan #(
      .NUM_DIGITS(N), .CLKDIV_RATIO(R), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0), .BRIGHT_W(BW)
   ) u_dut_hi (
      .clk(clk), .rst(rst), .inp(inp), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
      .brightness(brightness), .sel(sel_hi), .data(data_hi), .frame_done(frame_done_hi)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: everything derived from t, the number of clock edges since reset released.
   logic [7:0]  glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                   8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
   int          t = 0;
   logic [15:0] m_stage = '0, m_disp = '0;
   logic [3:0]  m_sdp = '0, m_ddp = '0;
   logic [3:0]  exp_sel = '0;
   logic [7:0]  exp_data = '0;
   logic        exp_fd = 1'b0;

   function automatic logic [7:0] model_digit(input int d, input logic [15:0] v,
                                              input logic [3:0] dpv, input logic lz);
      logic [7:0] g;
      int nib;
      nib = (v >> (4 * d)) & 15;
      g = glyph_tab[nib];
      if (LZ_EN && lz && d >= 1 && (v >> (4 * d)) == 16'h0) g = 8'h00;
      if (dpv[d]) g = g | 8'h80;
      return g;
   endfunction

   always @(posedge clk or posedge rst) begin
      int  m_idx;
      bit  m_bnd, m_on;
      if (rst) begin
         t = 0;
         m_stage = '0; m_disp = '0; m_sdp = '0; m_ddp = '0;
         exp_sel = '0; exp_data = '0; exp_fd = 1'b0;
      end else begin
         m_idx = (t / R) % N;
         m_bnd = ((t % R) == R - 1) && (m_idx == N - 1);
         m_on  = (brightness == 4'hF) || ((t % 16) < brightness);
         exp_sel  = m_on ? 4'(1 << m_idx) : 4'h0;
         exp_data = m_on ? model_digit(m_idx, m_disp, m_ddp, blank_lz) : 8'h00;
         exp_fd   = m_bnd;
         if (load) begin
            m_stage = inp;
            m_sdp   = dp_in;
         end
         if (m_bnd) begin
            m_disp = m_stage;
            m_ddp  = m_sdp;
         end
         t = t + 1;
      end
   end

   always @(negedge clk) begin
      check("model_sel",     sel,           4'(~exp_sel));
      check("model_data",    data,          8'(~exp_data));
      check("model_fd",      frame_done,    exp_fd);
      check("model_sel_hi",  sel_hi,        exp_sel);
      check("model_data_hi", data_hi,       8'(~exp_data));
      check("model_fd_hi",   frame_done_hi, exp_fd);
   end

   task automatic goto_edge(input int n);
      int guard;
      guard = 0;
      while (t < n && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (t < n) begin
         checks++;
         failures++;
         $display("FAIL goto_edge: reached %0d required %0d", t, n);
      end
   endtask

   task automatic count_active(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (sel != 4'b1111) cnt++;
      end
   endtask

   initial begin
      int cnt;
      repeat (3) @(negedge clk);
      check("rst_sel",  sel,        4'b1111);
      check("rst_data", data,       8'hFF);
      check("rst_fd",   frame_done, 1'b0);
      check("rst_sel_hi", sel_hi,   4'b0000);
      rst = 1'b0;

      // 1: first frame shows reset contents, new load appears after boundary
      inp = 16'h12AF; load = 1'b1;
      @(negedge clk); load = 1'b0;
      check("t1_e1_sel",  sel,  4'b1110);
      check("t1_e1_data", data, 8'hC0);
      goto_edge(16); check("t1_fd16", frame_done, 1'b1);
      goto_edge(17); check("t1_fd17", frame_done, 1'b0);
      check("t1_d0_sel",  sel,  4'b1110);
      check("t1_d0_data", data, 8'h8E);
      goto_edge(21);
      check("t1_d1_sel",  sel,  4'b1101);
      check("t1_d1_data", data, 8'h88);
      goto_edge(32); check("t1_fd32", frame_done, 1'b1);

      // 2: two loads mid-frame, last wins, current frame untouched
      goto_edge(36); inp = 16'h0000; load = 1'b1;
      goto_edge(37); load = 1'b0;
      goto_edge(38); inp = 16'h3333; load = 1'b1;
      goto_edge(39); load = 1'b0;
      goto_edge(40);
      check("t2_cur_sel",  sel,  4'b1101);
      check("t2_cur_data", data, 8'h88);
      goto_edge(45);
      check("t2_cur3_sel",  sel,  4'b0111);
      check("t2_cur3_data", data, 8'hF9);
      goto_edge(49);
      check("t2_new0_sel",  sel,  4'b1110);
      check("t2_new0_data", data, 8'hB0);
      goto_edge(57);
      check("t2_new2_sel",  sel,  4'b1011);
      check("t2_new2_data", data, 8'hB0);

      // 3: load in the boundary cycle goes straight to display
      goto_edge(63); inp = 16'h8888; load = 1'b1;
      goto_edge(64); load = 1'b0;
      goto_edge(65);
      check("t3_sel",  sel,  4'b1110);
      check("t3_data", data, 8'h80);

      // 4: brightness duty
      goto_edge(80); brightness = 4'd4;
      goto_edge(82); count_active(16, cnt); check("t4_duty4", cnt, 4);
      brightness = 4'd0;
      goto_edge(100); count_active(16, cnt); check("t4_duty0", cnt, 0);
      brightness = 4'd15;
      goto_edge(118); count_active(16, cnt); check("t4_duty15", cnt, 16);

      // 5: leading-zero blanking (ignored when not compiled in)
      goto_edge(136); inp = 16'h0040; dp_in = 4'b1000; blank_lz = 1'b1; load = 1'b1;
      goto_edge(137); load = 1'b0;
      goto_edge(145);
      check("t5_d0_sel", sel, 4'b1110); check("t5_d0_data", data, 8'hC0);
      goto_edge(149);
      check("t5_d1_sel", sel, 4'b1101); check("t5_d1_data", data, 8'h99);
      goto_edge(153);
      check("t5_d2_sel", sel, 4'b1011); check("t5_d2_data", data, LZ_EN ? 8'hFF : 8'hC0);
      goto_edge(157);
      check("t5_d3_sel_hi", sel_hi, 4'b1000); check("t5_d3_data", data, LZ_EN ? 8'h7F : 8'h40);

      // 6: async reset between edges, scan restarts with cleared buffers
      goto_edge(160);
      #1 rst = 1'b1;
      #1;
      check("t6_sel",     sel,        4'b1111);
      check("t6_data",    data,       8'hFF);
      check("t6_sel_hi",  sel_hi,     4'b0000);
      check("t6_data_hi", data_hi,    8'hFF);
      check("t6_fd",      frame_done, 1'b0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t6_e1_sel_hi",  sel_hi,  4'b0001);
      check("t6_e1_data_hi", data_hi, 8'hC0);
      goto_edge(5);
      check("t6_e5_sel_hi",  sel_hi,  4'b0010);
      check("t6_e5_data_hi", data_hi, LZ_EN ? 8'hFF : 8'hC0);
      goto_edge(21);
      check("t6_e21_sel", sel, 4'b1101);
      check("t6_e21_data", data, LZ_EN ? 8'hFF : 8'hC0);
      goto_edge(24);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
